// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped read-cache fill controller.
// 4 lines x 8 bytes; byte address splits as {tag, line[4:3], offset[2:0]}.
package cache_pkg;

    localparam int OFF_W      = 3;
    localparam int LINE_W     = 2;
    localparam int NUM_LINES  = 4;
    localparam int LINE_BYTES = 8;

    // Offset of the final beat of a line fill
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        SETTLE,
        RESP
    } state_t;

endpackage

// File: rtl/cache_tag_store.sv
// Tag + valid store for the 4-line direct-mapped cache.
// Synchronous set/clear of one entry, combinational read-compare producing hit.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int TAG_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LINE_W-1:0] line,
    input  logic [TAG_W-1:0]  tag,
    input  logic              set_en,
    input  logic              clr_en,
    output logic              hit
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];

    // Valid bits: all cleared by reset; a miss clears the entry, a completed fill sets it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (set_en) begin
            valid[line] <= 1'b1;
        end else if (clr_en) begin
            valid[line] <= 1'b0;
        end
    end

    // Tag storage is plain data; it is only meaningful while its valid bit is set
    always_ff @(posedge clk) begin
        if (set_en) begin
            tags[line] <= tag;
        end
    end

    assign hit = valid[line] && (tags[line] == tag);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Direct-mapped read-cache controller: tag lookup, byte-by-byte line fill from
// main memory into a negedge-clocked 4x8 data array, and single-byte response.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16
`ifdef CACHE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [7:0]        resp_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [LINE_W-1:0] wrline,
    output logic [OFF_W-1:0]  wroffset,
    output logic [7:0]        wdata,
    output logic              wren,
    output logic [LINE_W-1:0] rdline,
    output logic [OFF_W-1:0]  rdoffset,
    input  logic [7:0]        cache_q
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - OFF_W - LINE_W;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  beat;
    logic [TAG_W-1:0]  cur_tag;
    logic [LINE_W-1:0] cur_line;
    logic              hit;
    logic              tag_set;
    logic              tag_clr;

    assign cur_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign cur_line = addr_q[OFF_W +: LINE_W];

    cache_tag_store #(
        .TAG_W (TAG_W)
    ) u_tag_store (
        .clk    (clk),
        .reset  (reset),
        .line   (cur_line),
        .tag    (cur_tag),
        .set_en (tag_set),
        .clr_en (tag_clr),
        .hit    (hit)
    );

    // State register, latched request address and fill beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            beat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
            end
            if (state == LOOKUP) begin
                beat <= '0;
            end else if (state == FILL && mem_ack) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        mem_req    = 1'b0;
        wren       = 1'b0;
        tag_set    = 1'b0;
        tag_clr    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = RESP;
                end else begin
                    // Invalidate before refilling so an abandoned fill never looks valid
                    tag_clr   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wren = 1'b1;
                    if (beat == LAST_BEAT) begin
                        tag_set   = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // Array writes on negedge; one idle cycle lets the last byte land
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = cache_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr = {cur_tag, cur_line, beat};
    assign wrline   = cur_line;
    assign wroffset = beat;
    assign wdata    = mem_data;
    assign rdline   = cur_line;
    assign rdoffset = addr_q[OFF_W-1:0];

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, updated once per lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Testbench for cache_fill_ctrl: directed vector table, hand-written reset and
// stats sequences, and randomized reads checked against a line/tag model.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic [1:0]  wrline;
    logic [2:0]  wroffset;
    logic [7:0]  wdata;
    logic        wren;
    logic [1:0]  rdline;
    logic [2:0]  rdoffset;
    logic [7:0]  cache_q;
`ifdef CACHE_STATS_EN
    logic [1:0]  hit_cnt;
    logic [1:0]  miss_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [65536];
    logic [7:0]  arr [4][8];
    bit          mvalid [4];
    logic [10:0] mtag [4];

    typedef struct {
        logic [15:0] addr;
        int          gap;
        bit          spur;
        bit          exp_hit;
    } vec_t;
    vec_t tbl [10];

    cache_fill_ctrl #(
        .ADDR_W (16)
`ifdef CACHE_STATS_EN
        ,
        .STAT_W (2)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .wrline     (wrline),
        .wroffset   (wroffset),
        .wdata      (wdata),
        .wren       (wren),
        .rdline     (rdline),
        .rdoffset   (rdoffset),
        .cache_q    (cache_q)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the negedge-clocked data array
    always @(negedge clk) begin
        if (wren) arr[wrline][wroffset] <= wdata;
    end
    assign cache_q = arr[rdline][rdoffset];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One complete read transaction; entered and left 1 time unit after a posedge
    task automatic read_txn(input logic [15:0] addr, input int gap, input bit spur, output bit obs_hit);
        logic [1:0]  ln;
        logic [10:0] tg;
        logic [15:0] eaddr;
        logic [7:0]  rdat;
        bit          exp_hit, got, sawmem, bad_wr, late_req;
        int          w, cyc, beats, gapcnt, wrc, resp_cyc, last_ack, addr_err;
        ln = addr[4:3];
        tg = addr[15:5];
        exp_hit = mvalid[ln] && (mtag[ln] == tg);
        got = 0; sawmem = 0; bad_wr = 0; late_req = 0;
        beats = 0; gapcnt = gap; wrc = 0; resp_cyc = 0; last_ack = 0; addr_err = 0;
        rdat = '0;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr = addr;
        mem_ack = spur;
        mem_data = 8'($urandom);
        #1;
        if (spur) chk("idle_spur_wren", wren, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 16'($urandom);
        cyc = 1;
        while (!got && cyc < 400) begin
            mem_ack = 1'b0;
            if (resp_valid) begin
                got = 1;
                resp_cyc = cyc;
                rdat = resp_data;
            end else if (mem_req) begin
                sawmem = 1;
                if (beats == 8) late_req = 1;
                if (gapcnt == 0 && beats < 8) begin
                    eaddr = {addr[15:3], beats[2:0]};
                    if (mem_addr !== eaddr) addr_err++;
                    mem_ack = 1'b1;
                    mem_data = mem[mem_addr];
                    beats++;
                    last_ack = cyc;
                    gapcnt = gap;
                end else if (gapcnt > 0) begin
                    gapcnt--;
                end
            end else if (spur) begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_data = 8'($urandom);
            end
            #1;
            if (wren) begin
                wrc++;
                if (!(mem_req && mem_ack) || wrline !== ln || wroffset !== 3'(beats - 1) || wdata !== mem_data)
                    bad_wr = 1;
            end
            if (!got) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk("resp_seen", got, 1);
        chk("resp_data", rdat, mem[addr]);
        chk("wren_fields", bad_wr, 0);
        if (exp_hit) begin
            chk("hit_latency", resp_cyc, 2);
            chk("hit_no_memreq", sawmem, 0);
            chk("hit_no_wren", wrc, 0);
        end else begin
            chk("miss_beats", beats, 8);
            chk("miss_wren_cnt", wrc, 8);
            chk("miss_latency", resp_cyc - last_ack, 2);
            chk("miss_addr_seq", addr_err, 0);
            chk("memreq_drop", late_req, 0);
            mvalid[ln] = 1'b1;
            mtag[ln] = tg;
        end
        obs_hit = !sawmem;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", resp_valid, 0);
        chk("ready_after_resp", req_ready, 1);
    endtask

    initial begin
        bit          h;
        int          beats, cyc;
        logic [10:0] rt;
        logic [15:0] ra;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int l = 0; l < 4; l++)
            for (int o = 0; o < 8; o++) arr[l][o] = 8'($urandom);

        tbl[0] = '{16'h0013, 0, 1'b0, 1'b0};
        tbl[1] = '{16'h0015, 0, 1'b0, 1'b1};
        tbl[2] = '{16'h0113, 0, 1'b0, 1'b0};
        tbl[3] = '{16'h0013, 3, 1'b1, 1'b0};
        tbl[4] = '{16'h0017, 0, 1'b1, 1'b1};
        tbl[5] = '{16'h0008, 1, 1'b0, 1'b0};
        tbl[6] = '{16'h000F, 0, 1'b0, 1'b1};
        tbl[7] = '{16'hFFE0, 2, 1'b0, 1'b0};
        tbl[8] = '{16'hFFE7, 0, 1'b0, 1'b1};
        tbl[9] = '{16'h001B, 0, 1'b1, 1'b0};

        do_reset();
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rdline", rdline, 0);
        chk("rst_rdoffset", rdoffset, 0);

        for (int i = 0; i < 10; i++) begin
            read_txn(tbl[i].addr, tbl[i].gap, tbl[i].spur, h);
            chk($sformatf("vec%0d_hit", i), h, tbl[i].exp_hit);
        end

        // Reset during a fill after four beats
        req_valid = 1'b1;
        req_addr = 16'h0040;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 4 && cyc < 50) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                mem_ack = 1'b1;
                mem_data = mem[mem_addr];
                beats++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_ack = 1'b0;
        chk("prefill_beats", beats, 4);
        chk("pre_reset_memreq", mem_req, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("midfill_rst_memreq", mem_req, 0);
        chk("midfill_rst_ready", req_ready, 1);
        chk("midfill_rst_resp", resp_valid, 0);
        read_txn(16'h0040, 0, 1'b0, h);
        chk("refill_after_rst_hit", h, 0);
        read_txn(16'h0046, 0, 1'b0, h);
        chk("after_refill_hit", h, 1);

        // Randomized reads over a few tags so hits, misses and evictions all occur
        for (int i = 0; i < 40; i++) begin
            rt = 11'($urandom_range(0, 2));
            ra = {rt, 5'($urandom)};
            read_txn(ra, $urandom_range(0, 2), 1'($urandom_range(0, 1)), h);
        end

`ifdef CACHE_STATS_EN
        do_reset();
        chk("stat_rst_hit", hit_cnt, 0);
        chk("stat_rst_miss", miss_cnt, 0);
        read_txn(16'h0013, 0, 1'b0, h);
        read_txn(16'h0013, 0, 1'b0, h);
        read_txn(16'h0014, 0, 1'b0, h);
        read_txn(16'h0015, 0, 1'b0, h);
        chk("stat_miss_cnt", miss_cnt, 1);
        chk("stat_hit_cnt", hit_cnt, 3);
        read_txn(16'h0016, 0, 1'b0, h);
        chk("stat_hit_sat", hit_cnt, 3);
        chk("stat_miss_hold", miss_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
